// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM states and the
// architectural constants the stage and its IF/ID register agree on.
package fetch_stage_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fstate_t;

  localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear wins over enable, async reset to a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus4,
  input  logic        d_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (clr) begin
      instr    <= NOP;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= d_instr;
      pc_plus4 <= d_pc_plus4;
      valid    <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register and next-PC mux, run/halt FSM, IF/ID register
// and a count of valid instructions handed to Decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_C,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_C
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  input  logic [31:0] pc_jump_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  localparam logic [30:0] WORD_LIM = 31'(IMEM_WORDS);

  fstate_t     state, state_nxt;
  logic [31:0] pc_nxt, pc_plus4_f;
  logic        fault_f, redirect, halt_go, load_ok, ifid_fill;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;
  assign fault_f    = (state == RUN) &&
                      ((pc_f[1:0] != 2'b00) || ({1'b0, pc_f[31:2]} >= WORD_LIM));
  assign redirect   = !stall_f && (jump_d || pc_src_d);
  // Halt/fault only counts on a quiet cycle; with a redirect the fetch is wrong-path.
  assign halt_go    = (state == RUN) && !stall_f && !redirect && !stall_d && !flush_d &&
                      (fault_f || (imem_rd == HALT_WORD));
  assign load_ok    = (state == RUN) && !fault_f;
  assign ifid_fill  = !flush_d && !stall_d && load_ok;
  assign halted     = (state == HALTED);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_f;
    if (state == RUN) begin
      if (stall_f)       pc_nxt = pc_f;
      else if (jump_d)   pc_nxt = pc_jump_d;
      else if (pc_src_d) pc_nxt = pc_branch_d;
      else if (halt_go)  pc_nxt = pc_f;
      else               pc_nxt = pc_plus4_f;
      if (halt_go) state_nxt = HALTED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc_f        <= RESET_PC;
      addr_err    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_nxt;
      if (halt_go && fault_f) addr_err <= 1'b1;
      if (ifid_fill) fetch_count <= fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall_d),
    .clr        (flush_d),
    .d_instr    (load_ok ? imem_rd : NOP),
    .d_pc_plus4 (load_ok ? pc_plus4_f : 32'h0),
    .d_valid    (load_ok),
    .instr      (instr_d),
    .pc_plus4   (pc_plus4_d),
    .valid      (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage; memory returns 0xA000_0000|addr
// except the halt word at 0x20.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rd;
  logic        stall_f, stall_d, flush_d, pc_src_d, jump_d;
  logic [31:0] pc_branch_d, pc_jump_d;
  logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
  logic        valid_d, halted, addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr == 32'h20) ? 32'hFFFF_FFFF : (32'hA000_0000 | imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
    .jump_d(jump_d), .pc_jump_d(pc_jump_d),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .halted(halted), .addr_err(addr_err), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        sf, sd, fl, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] pc, instr, pp4;
    logic        v, h, e;
    logic [31:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " pc_f"},        pc_f,        v.pc);
    chk({tag, " imem_addr"},   imem_addr,   v.pc);
    chk({tag, " instr_d"},     instr_d,     v.instr);
    chk({tag, " pc_plus4_d"},  pc_plus4_d,  v.pp4);
    chk({tag, " valid_d"},     32'(valid_d),  32'(v.v));
    chk({tag, " halted"},      32'(halted),   32'(v.h));
    chk({tag, " addr_err"},    32'(addr_err), 32'(v.e));
    chk({tag, " fetch_count"}, fetch_count, v.cnt);
  endtask

  task automatic apply(input string tag, input vec_t v);
    stall_f = v.sf; stall_d = v.sd; flush_d = v.fl;
    pc_src_d = v.br; pc_branch_d = v.bt; jump_d = v.jp; pc_jump_d = v.jt;
    @(posedge clk); #1;
    check_outs(tag, v);
  endtask

  task automatic do_reset();
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_d = 0; jump_d = 0;
    pc_branch_d = 0; pc_jump_d = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(input logic sf, sd, fl, br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt,
                              input logic [31:0] pc, instr, pp4,
                              input logic v, h, e, input logic [31:0] cnt);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fl = fl; r.br = br; r.bt = bt; r.jp = jp; r.jt = jt;
    r.pc = pc; r.instr = instr; r.pp4 = pp4; r.v = v; r.h = h; r.e = e; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[17];
  vec_t rst_v;

  initial begin
    rst_v = mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0,0, 0);
    //           sf sd fl br bt     jp jt      pc     instr         pp4    v h e cnt
    tbl[0]  = mk(0,0,0,0,0,     0,0,       32'h04, 32'hA000_0000, 32'h04, 1,0,0, 1);
    tbl[1]  = mk(0,0,0,0,0,     0,0,       32'h08, 32'hA000_0004, 32'h08, 1,0,0, 2);
    tbl[2]  = mk(0,0,0,0,0,     0,0,       32'h0C, 32'hA000_0008, 32'h0C, 1,0,0, 3);
    tbl[3]  = mk(0,0,0,0,0,     0,0,       32'h10, 32'hA000_000C, 32'h10, 1,0,0, 4);
    tbl[4]  = mk(1,1,0,1,32'h90,0,0,       32'h10, 32'hA000_000C, 32'h10, 1,0,0, 4);
    tbl[5]  = mk(1,1,0,0,0,     0,0,       32'h10, 32'hA000_000C, 32'h10, 1,0,0, 4);
    tbl[6]  = mk(1,1,1,0,0,     0,0,       32'h10, 32'h0,         32'h0,  0,0,0, 4);
    tbl[7]  = mk(0,0,0,1,32'h40,0,0,       32'h40, 32'hA000_0010, 32'h14, 1,0,0, 5);
    tbl[8]  = mk(0,0,0,1,32'h60,1,32'h80,  32'h80, 32'hA000_0040, 32'h44, 1,0,0, 6);
    tbl[9]  = mk(0,0,0,0,0,     1,32'h18,  32'h18, 32'hA000_0080, 32'h84, 1,0,0, 7);
    tbl[10] = mk(0,0,0,0,0,     0,0,       32'h1C, 32'hA000_0018, 32'h1C, 1,0,0, 8);
    tbl[11] = mk(0,0,0,0,0,     0,0,       32'h20, 32'hA000_001C, 32'h20, 1,0,0, 9);
    // halt word under a taken branch is wrong-path: fetch continues
    tbl[12] = mk(0,0,0,1,32'h24,0,0,       32'h24, 32'hFFFF_FFFF, 32'h24, 1,0,0, 10);
    tbl[13] = mk(0,0,0,0,0,     1,32'h20,  32'h20, 32'hA000_0024, 32'h28, 1,0,0, 11);
    tbl[14] = mk(0,0,0,0,0,     0,0,       32'h20, 32'hFFFF_FFFF, 32'h24, 1,1,0, 12);
    tbl[15] = mk(0,0,0,0,0,     0,0,       32'h20, 32'h0,         32'h0,  0,1,0, 12);
    tbl[16] = mk(0,0,0,1,32'h44,1,32'h100, 32'h20, 32'h0,         32'h0,  0,1,0, 12);

    do_reset();
    check_outs("reset", rst_v);
    for (int i = 0; i < 17; i++) apply($sformatf("v%0d", i), tbl[i]);

    // last legal word, then the first out-of-range one
    do_reset();
    apply("j_ffc",  mk(0,0,0,0,0,1,32'hFFC, 32'hFFC,  32'hA000_0000, 32'h04,  1,0,0, 1));
    apply("f_ffc",  mk(0,0,0,0,0,0,0,       32'h1000, 32'hA000_0FFC, 32'h1000,1,0,0, 2));
    apply("oor",    mk(0,0,0,0,0,0,0,       32'h1000, 32'h0,         32'h0,   0,1,1, 2));
    apply("oor_hd", mk(0,0,0,0,0,1,32'h8,   32'h1000, 32'h0,         32'h0,   0,1,1, 2));

    // reset asserted mid-HALTED, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_rst", rst_v);
    @(posedge clk); #1;
    reset = 1'b0;

    // misaligned target
    apply("j_002",  mk(0,0,0,0,0,1,32'h2,   32'h2,    32'hA000_0000, 32'h04,  1,0,0, 1));
    apply("misal",  mk(0,0,0,0,0,0,0,       32'h2,    32'h0,         32'h0,   0,1,1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. Owns the PC register, drives the combinational instruction memory address and captures the returned word into the IF/ID pipeline register. Applies hazard-unit stall/flush controls and branch/jump redirects resolved in Decode. Provides a halt mechanism and a retired-fetch counter for simulation bookkeeping.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 1024, instruction memory depth in words; word index >= IMEM_WORDS is an address error
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  32  byte address to instruction memory (= pc_f)
imem_rd  in  32  instruction word from memory, valid in the same cycle
stall_f  in  1  hold PC
stall_d  in  1  hold IF/ID register
flush_d  in  1  clear IF/ID register to a bubble
pc_src_d  in  1  taken branch resolved in Decode
pc_branch_d  in  32  branch target
jump_d  in  1  jump resolved in Decode
pc_jump_d  in  32  jump target
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID instruction
pc_plus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped (HALTED state)
addr_err  out  1  sticky: misaligned or out-of-range PC seen
fetch_count  out  32  number of valid instructions written into IF/ID

Behaviour:
- Reset (async, any time incl. mid-operation): pc_f=RESET_PC; instr_d=0, pc_plus4_d=0, valid_d=0; state RUN; halted=0, addr_err=0, fetch_count=0.
- imem_addr = pc_f combinationally; pc_plus4_f = pc_f + 32'd4, modulo 2^32 (wraps, no flag).
- Fault check (combinational, RUN only): fault_f = pc_f[1:0]!=0 or pc_f[31:2] >= IMEM_WORDS.
- Next PC, RUN state: stall_f=1 -> hold (redirects ignored; hazard unit re-presents them). Else jump_d -> pc_jump_d; else pc_src_d -> pc_branch_d; else pc_plus4_f. Jump beats branch when both asserted.
- redirect = !stall_f & (jump_d | pc_src_d).
- IF/ID update each edge, priority: flush_d -> bubble (instr 0, pc_plus4 0, valid 0); else stall_d -> hold; else load {imem_rd, pc_plus4_f, valid=1} in RUN with no fault, bubble otherwise. flush_d beats stall_d.
- FSM RUN -> HALTED when !stall_f & !redirect & !stall_d & !flush_d and either (a) imem_rd==HALT_WORD & !fault_f: halt word is loaded into IF/ID with valid=1 and PC frozen at its address; or (b) fault_f: addr_err<=1, bubble loaded, PC frozen. Halt/fault in a cycle with a redirect is wrong-path and ignored.
- HALTED: PC frozen; IF/ID loads bubbles (still honouring stall_d hold and flush_d); redirects ignored; halted=1. Exit only by reset.
- fetch_count increments by 1 on every edge where IF/ID is loaded with valid=1 (incl. halt word); wraps at 2^32.
- Stall and flush are level-sensitive, one decision per edge; no internal buffering.

Decomposition:
- Shared package/header: FSM state encoding (RUN=1'b0, HALTED=1'b1), HALT_WORD, RESET_PC, NOP/bubble constant 32'h0.
- One natural sub-module: if_id_reg (instr, pc_plus4, valid with enable/clear, async reset). PC mux, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, imem returns addr-indexed words -> pc_f 0,4,8,12; instr_d follows one cycle later; valid_d=1 from cycle 2; fetch_count=4.
- pc_f=8, pc_src_d=1, pc_branch_d=0x40 -> next pc_f=0x40; with jump_d=1, pc_jump_d=0x80 same cycle -> pc_f=0x80.
- stall_f=stall_d=1 for 2 cycles at pc_f=0x10 -> pc_f, instr_d and fetch_count unchanged; flush_d=1 with stall_d=1 -> valid_d=0, instr_d=0.
- HALT_WORD fetched at 0x20 -> next edge instr_d=0xFFFFFFFF, valid_d=1, halted=1; further cycles pc_f=0x20, valid_d=0; redirect ignored.
- HALT_WORD in F while pc_src_d=1 -> no halt, pc_f=branch target.
- Jump to 0x1000 (IMEM_WORDS=1024) -> next edge addr_err=1, halted=1, valid_d=0; jump to 0x2 -> same; assert reset mid-HALTED -> all outputs to reset values asynchronously.
